// File: rtl/mio_counter_x3.sv
// mio_counter_x3: three-channel programmable down-counter/timer on the MIO bus.
//
// Ports:
//   clk            system clock, all state on rising edge
//   rst            asynchronous active-low reset
//   counter_we     one-cycle write strobe from the bus decoder
//   counter_sel    write target: 0..2 = channel reload register, 3 = control
//   Peripheral_in  write data
//   counter_rd_sel read-back select: 0..2 = channel count, 3 = control
//   counter_out    registered read-back data (one-cycle latency)
//   counterN_out   channel output lines
//
// Control register: bits[2:0] EN per channel, bits[5:4]/[7:6]/[9:8] MODE for
// ch0/ch1/ch2 (0 one-shot, 1 rate, 2 square, 3 hold). Other bits stored as-is.
//
// Build option: define COUNTER_PRESCALE_EN to enable the shared prescaler
// (control bits[23:16] = divisor P, counting advances every P+1 clocks).
module mio_counter_x3 #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             counter_we,
  input  logic [1:0]       counter_sel,
  input  logic [WIDTH-1:0] Peripheral_in,
  input  logic [1:0]       counter_rd_sel,
  output logic [WIDTH-1:0] counter_out,
  output logic             counter0_out,
  output logic             counter1_out,
  output logic             counter2_out
);

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'd0,
    MODE_RATE    = 2'd1,
    MODE_SQUARE  = 2'd2,
    MODE_HOLD    = 2'd3
  } mode_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] ctrl;
  logic [WIDTH-1:0] count      [3];
  logic [WIDTH-1:0] reload     [3];
  logic [WIDTH-1:0] count_nxt  [3];
  logic [WIDTH-1:0] reload_nxt [3];
  logic [2:0]       out;
  logic [2:0]       out_nxt;
  mode_t            mode       [3];
  logic             ctrl_wr;
  logic             tick;

  assign ctrl_wr = counter_we && (counter_sel == 2'd3);

`ifdef COUNTER_PRESCALE_EN
  logic [PRESCALE_W-1:0] pre_cnt;
  logic [PRESCALE_W-1:0] pre_div;

  assign pre_div = ctrl[16 +: PRESCALE_W];
  assign tick    = (pre_cnt == pre_div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
    end else if (ctrl_wr || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRESCALE_W'(1);
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      mode[i]       = mode_t'(ctrl[4 + 2*i +: 2]);
      count_nxt[i]  = count[i];
      reload_nxt[i] = reload[i];
      out_nxt[i]    = out[i];
      if (counter_we && (counter_sel == 2'(i))) begin
        // A channel write overrides any decrement or terminal event this edge.
        count_nxt[i]  = Peripheral_in;
        reload_nxt[i] = Peripheral_in;
        out_nxt[i]    = (mode[i] == MODE_SQUARE);
      end else begin
        // Rate-mode pulse lasts one clk regardless of enable or prescale.
        if (mode[i] == MODE_RATE) begin
          out_nxt[i] = 1'b0;
        end
        if (ctrl[i] && tick && (count[i] != '0) && (mode[i] != MODE_HOLD)) begin
          if (count[i] == ONE) begin
            unique case (mode[i])
              MODE_ONESHOT: begin
                count_nxt[i] = '0;
                out_nxt[i]   = 1'b1;
              end
              MODE_RATE: begin
                count_nxt[i] = reload[i];
                out_nxt[i]   = 1'b1;
              end
              MODE_SQUARE: begin
                count_nxt[i] = reload[i];
                out_nxt[i]   = ~out[i];
              end
              default: ;
            endcase
          end else begin
            count_nxt[i] = count[i] - ONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl        <= '0;
      out         <= '0;
      counter_out <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        count[i]  <= '0;
        reload[i] <= '0;
      end
    end else begin
      if (ctrl_wr) begin
        ctrl <= Peripheral_in;
      end
      out <= out_nxt;
      for (int unsigned i = 0; i < 3; i++) begin
        count[i]  <= count_nxt[i];
        reload[i] <= reload_nxt[i];
      end
      case (counter_rd_sel)
        2'd0:    counter_out <= count[0];
        2'd1:    counter_out <= count[1];
        2'd2:    counter_out <= count[2];
        default: counter_out <= ctrl;
      endcase
    end
  end

  assign counter0_out = out[0];
  assign counter1_out = out[1];
  assign counter2_out = out[2];

endmodule

// File: tb/tb_mio_counter_x3.sv
// Self-checking bench for mio_counter_x3 (default build, prescaler disabled).
module tb_mio_counter_x3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  sel = '0;
  logic [31:0] data = '0;
  logic [1:0]  rd_sel = '0;
  logic [31:0] counter_out;
  logic        counter0_out, counter1_out, counter2_out;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  string       phase = "init";

  // Reference model state: what a channel holds after each edge.
  logic [31:0] m_ctrl, m_rd;
  logic [31:0] m_cnt [3];
  logic [31:0] m_rel [3];
  logic [2:0]  m_out;

  mio_counter_x3 #(.WIDTH(32), .PRESCALE_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .counter_we     (we),
    .counter_sel    (sel),
    .Peripheral_in  (data),
    .counter_rd_sel (rd_sel),
    .counter_out    (counter_out),
    .counter0_out   (counter0_out),
    .counter1_out   (counter1_out),
    .counter2_out   (counter2_out)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] dut_outs();
    return {counter2_out, counter1_out, counter0_out};
  endfunction

  task automatic model_reset();
    m_ctrl = '0;
    m_rd   = '0;
    m_out  = '0;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = '0;
      m_rel[i] = '0;
    end
  endtask

  // One clock: predict from pre-edge state and inputs, advance, compare.
  task automatic cycle();
    logic [31:0] n_ctrl, n_rd;
    logic [31:0] n_cnt [3];
    logic [31:0] n_rel [3];
    logic [2:0]  n_out;
    int          md;
    logic        fires;
    n_ctrl = m_ctrl;
    n_rd   = m_rd;
    n_out  = m_out;
    for (int c = 0; c < 3; c++) begin
      n_cnt[c] = m_cnt[c];
      n_rel[c] = m_rel[c];
    end
    if (rst) begin
      if (we && sel == 2'd3) n_ctrl = data;
      n_rd = (rd_sel == 2'd3) ? m_ctrl : m_cnt[rd_sel];
      for (int c = 0; c < 3; c++) begin
        md = int'((m_ctrl >> (4 + 2*c)) & 32'h3);
        if (we && int'(sel) == c) begin
          n_cnt[c] = data;
          n_rel[c] = data;
          n_out[c] = (md == 2);
        end else if (md != 3) begin
          fires = m_ctrl[c] && (m_cnt[c] == 1);
          if (m_ctrl[c] && m_cnt[c] > 1) n_cnt[c] = m_cnt[c] - 1;
          if (fires) n_cnt[c] = (md == 0) ? 32'd0 : m_rel[c];
          case (md)
            0: if (fires) n_out[c] = 1'b1;
            1: n_out[c] = fires;
            default: if (fires) n_out[c] = ~m_out[c];
          endcase
        end
      end
    end
    @(posedge clk);
    #1;
    m_ctrl = n_ctrl;
    m_rd   = n_rd;
    m_out  = n_out;
    for (int c = 0; c < 3; c++) begin
      m_cnt[c] = n_cnt[c];
      m_rel[c] = n_rel[c];
    end
    n_checks++;
    if (counter_out !== m_rd) begin
      n_errors++;
      $display("FAIL %s model counter_out: got %0h expected %0h", phase, counter_out, m_rd);
    end
    n_checks++;
    if (dut_outs() !== m_out) begin
      n_errors++;
      $display("FAIL %s model outs: got %b expected %b", phase, dut_outs(), m_out);
    end
  endtask

  task automatic write(input logic [1:0] s, input logic [31:0] d);
    we   = 1'b1;
    sel  = s;
    data = d;
    cycle();
    we   = 1'b0;
  endtask

  task automatic test_reset();
    phase = "reset";
    model_reset();
    #12;
    n_checks++;
    if (counter_out !== 32'd0 || dut_outs() !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_state: got out=%0h lines=%b expected 0/000", counter_out, dut_outs());
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    write(2'd3, 32'h001);
    write(2'd0, 32'd50);
    rd_sel = 2'd0;
    for (int k = 0; k < 5; k++) cycle();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (counter_out !== 32'd0 || dut_outs() !== 3'b000) begin
      n_errors++;
      $display("FAIL midcount_reset: got out=%0h lines=%b expected 0/000", counter_out, dut_outs());
    end
    cycle();
    #1;
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rd_sel = 2'(k % 3);
      cycle();
      n_checks++;
      if (counter_out !== 32'd0 || dut_outs() !== 3'b000) begin
        n_errors++;
        $display("FAIL post_reset_idle: got out=%0h lines=%b expected 0/000", counter_out, dut_outs());
      end
    end
  endtask

  task automatic test_oneshot();
    phase = "oneshot";
    write(2'd3, 32'h001);
    rd_sel = 2'd0;
    write(2'd0, 32'd5);
    for (int k = 1; k <= 25; k++) begin
      cycle();
      n_checks++;
      if (counter0_out !== (k >= 5)) begin
        n_errors++;
        $display("FAIL oneshot_out k=%0d: got %b expected %b", k, counter0_out, k >= 5);
      end
      if (k >= 6) begin
        n_checks++;
        if (counter_out !== 32'd0) begin
          n_errors++;
          $display("FAIL oneshot_count k=%0d: got %0d expected 0", k, counter_out);
        end
      end
    end
  endtask

  task automatic test_rate();
    phase = "rate";
    write(2'd3, 32'h042);
    rd_sel = 2'd1;
    write(2'd1, 32'd3);
    for (int k = 1; k <= 9; k++) begin
      cycle();
      n_checks++;
      if (counter1_out !== (k % 3 == 0) || counter_out !== 32'(3 - ((k - 1) % 3))) begin
        n_errors++;
        $display("FAIL rate k=%0d: got out=%b count=%0d expected %b/%0d", k, counter1_out,
                 counter_out, k % 3 == 0, 3 - ((k - 1) % 3));
      end
    end
  endtask

  task automatic test_square();
    phase = "square";
    write(2'd3, 32'h204);
    rd_sel = 2'd2;
    write(2'd2, 32'd4);
    for (int k = 1; k <= 8; k++) begin
      cycle();
      n_checks++;
      if (counter2_out !== (1'b1 ^ 1'((k / 4) & 1))) begin
        n_errors++;
        $display("FAIL square_toggle k=%0d: got %b", k, counter2_out);
      end
    end
    cycle();
    write(2'd3, 32'h200);
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_checks++;
      if (counter2_out !== 1'b1 || counter_out !== 32'd2) begin
        n_errors++;
        $display("FAIL square_freeze: got out=%b count=%0d expected 1/2", counter2_out, counter_out);
      end
    end
    write(2'd3, 32'h204);
    for (int k = 0; k < 8; k++) cycle();
  endtask

  task automatic test_collision();
    phase = "collision";
    write(2'd3, 32'h011);
    rd_sel = 2'd0;
    write(2'd0, 32'd7);
    for (int k = 0; k < 6; k++) cycle();
    write(2'd0, 32'd10);
    n_checks++;
    if (counter0_out !== 1'b0) begin
      n_errors++;
      $display("FAIL collision_out: got %b expected 0", counter0_out);
    end
    cycle();
    n_checks++;
    if (counter_out !== 32'd10) begin
      n_errors++;
      $display("FAIL collision_count: got %0d expected 10", counter_out);
    end
    rd_sel = 2'd3;
    write(2'd3, 32'h2C7);
    cycle();
    n_checks++;
    if (counter_out !== 32'h2C7) begin
      n_errors++;
      $display("FAIL ctrl_readback: got %0h expected 2c7", counter_out);
    end
  endtask

  task automatic test_random();
    phase = "random";
    for (int k = 0; k < 400; k++) begin
      we     = ($urandom_range(0, 3) == 0);
      sel    = 2'($urandom_range(0, 3));
      data   = (sel == 2'd3) ? $urandom : 32'($urandom_range(0, 12));
      rd_sel = 2'($urandom_range(0, 3));
      cycle();
    end
    we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_rate();
    test_square();
    test_collision();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
